// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full-add cell reused LSB-first, one bit per clock.
// Define SERIAL_ADDER_CIN_EN to add the cin port and seed the carry FF from it.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-2:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s, cn, c0;
  logic [WIDTH-1:0] rs_next;

`ifdef SERIAL_ADDER_CIN_EN
  assign c0 = cin;
`else
  assign c0 = 1'b0;
`endif

  // rs keeps only the WIDTH-1 bits gathered so far; the current bit completes the word.
  always_comb begin
    s       = ra[0] ^ rb[0] ^ c;
    cn      = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    rs_next = {s, rs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= c0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_next[WIDTH-1:1];
          c   <= cn;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= rs_next;
            cout  <= cn;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed plan steps plus random operands
// compared against an arithmetic reference (a + b [+ cin]).
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

`ifdef SERIAL_ADDER_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_ADDER_CIN_EN
    .cin  (cin),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y};
    if (CIN_EN) r = r + (W+1)'(ci);
    return r;
  endfunction

  // One complete operation; operands, cin and start are scrambled during RUN.
  task automatic add_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input string tag);
    logic [W:0] e;
    a = x; b = y; cin = ci; start = 1'b1;
    e = ref_add(x, y, cin);
    tick;
    for (int i = 0; i < int'(W); i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_sumhold"}, 32'(sum), 32'(last_sum));
      chk({tag, "_couthold"}, 32'(cout), 32'(last_cout));
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = 1'($urandom_range(0, 1));
      tick;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busyoff"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
    last_sum = e[W-1:0]; last_cout = e[W];
    start = 1'b0;
    tick;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W:0] e;
    rst = 1'b1; start = 1'b1; a = 8'h55; b = '0; cin = 1'b0;
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick;
    chk("rst_nostart", 32'(busy), 32'd0);

    add_op(8'h3C, 8'h0F, 1'b0, "basic");
    add_op(8'hFF, 8'h01, 1'b0, "ripple");
    add_op(8'hFF, 8'h00, 1'b1, "cin");
    add_op(8'hAA, 8'h55, 1'b1, "alt");

    // Back-to-back: start held high, second operands presented during the first RUN.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick;
    a = 8'h80; b = 8'h80;
    for (int i = 0; i < int'(W); i++) begin
      chk("b2b_wait1", 32'(done), 32'd0);
      tick;
    end
    e = ref_add(8'h01, 8'h02, 1'b0);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_sum1", 32'(sum), 32'(e[W-1:0]));
    chk("b2b_cout1", 32'(cout), 32'(e[W]));
    tick;
    for (int i = 0; i < int'(W); i++) begin
      chk("b2b_wait2", 32'(done), 32'd0);
      chk("b2b_busy2", 32'(busy), 32'd1);
      tick;
    end
    e = ref_add(8'h80, 8'h80, 1'b0);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_sum2", 32'(sum), 32'(e[W-1:0]));
    chk("b2b_cout2", 32'(cout), 32'(e[W]));
    start = 1'b0;
    tick;
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset on the fourth RUN cycle discards the operation.
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    last_sum = '0; last_cout = 1'b0;
    add_op(8'h12, 8'h34, 1'b1, "postrst");

    for (int n = 0; n < 20; n++)
      add_op(W'($urandom), W'($urandom), 1'($urandom), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
